tuning_word_gen: RTL

TUNING_WORD_GEN -- requirements
Module: tuning_word_gen

---
 rtl/tuning_word_gen.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/tuning_word_gen.sv
// tuning_word_gen: converts a three-digit keypad frequency entry with a unit
// code into a 32-bit NCO phase increment, TW = f * 2^32 / 4 MHz.
// N (0..999) is multiplied by a 32.16 fixed-point constant K with a
// sequential shift-add multiplier (one multiplier bit per cycle, 10 cycles).
// Optional build macro TW_ROUND_EN: when defined, the result is rounded
// half-up (saturating) instead of truncated.
module tuning_word_gen #(
   parameter int unsigned CLR_ON_ERR = 0
) (
   input  logic        clk_4MHz,
   input  logic        rst,
   input  logic        freq_select,
   input  logic [3:0]  digit0,
   input  logic [3:0]  digit1,
   input  logic [3:0]  digit2,
   input  logic [3:0]  unit,
   output logic [31:0] tuning_word,
   output logic        word_valid,
   output logic        busy,
   output logic        range_err
);

   typedef enum logic [2:0] {
      IDLE = 3'd0,
      LOAD = 3'd1,
      MUL  = 3'd2,
      DONE = 3'd3,
      ERR  = 3'd4
   } state_t;

   localparam logic [47:0] K_MHZ_MILLI = 48'd70369;
   localparam logic [47:0] K_HZ        = 48'd70368744;
   localparam logic [47:0] K_KHZ       = 48'd70368744178;
   localparam logic [47:0] K_MHZ       = 48'h4000_0000_0000;

   state_t      state_q, state_d;
   logic        fsel_q;
   logic        arm_q, arm_d;
   logic [3:0]  d0_q, d1_q, d2_q, unit_q;
   logic [9:0]  n_q, n_d;
   logic [57:0] mcand_q, mcand_d;
   logic [57:0] acc_q, acc_d;
   logic [3:0]  cnt_q, cnt_d;
   logic [31:0] tw_q, tw_d;
   logic        wv_q, wv_d;
   logic        rerr_q, rerr_d;

   logic        accept;
   logic [9:0]  n_calc;
   logic [47:0] k_sel;
   logic        unit_ok;
   logic        load_err;

`ifdef TW_ROUND_EN
   // Round half-up on bit 15 and clamp instead of wrapping on overflow.
   function automatic logic [31:0] tw_round(input logic [32:0] bits_47_15);
      logic [32:0] sum;
      sum = {1'b0, bits_47_15[32:1]} + {32'd0, bits_47_15[0]};
      return sum[32] ? 32'hffff_ffff : sum[31:0];
   endfunction
`endif

   // A request needs a fresh rising edge seen after freq_select was low at
   // least once since reset, so a level held through reset does not fire.
   assign accept = (state_q == IDLE) && arm_q && !fsel_q && freq_select;

   // Decimal value of the captured digits and per-unit scale constant.
   always_comb begin
      n_calc  = ({6'd0, d0_q} * 10'd100) + ({6'd0, d1_q} * 10'd10) + {6'd0, d2_q};
      k_sel   = 48'd0;
      unit_ok = 1'b1;
      case (unit_q)
         4'ha:    k_sel = K_MHZ_MILLI;
         4'hb:    k_sel = K_HZ;
         4'hc:    k_sel = K_KHZ;
         4'hd:    k_sel = K_MHZ;
         default: unit_ok = 1'b0;
      endcase
      load_err = (d0_q > 4'd9) || (d1_q > 4'd9) || (d2_q > 4'd9) || !unit_ok ||
                 ((unit_q == 4'hd) && (n_calc >= 10'd2));
   end

   // Next-state and datapath control for the conversion sequence.
   always_comb begin
      state_d = state_q;
      arm_d   = arm_q | ~freq_select;
      n_d     = n_q;
      mcand_d = mcand_q;
      acc_d   = acc_q;
      cnt_d   = cnt_q;
      tw_d    = tw_q;
      wv_d    = 1'b0;
      rerr_d  = rerr_q;
      case (state_q)
         IDLE: begin
            if (accept) state_d = LOAD;
         end
         LOAD: begin
            n_d     = n_calc;
            mcand_d = {10'd0, k_sel};
            acc_d   = 58'd0;
            cnt_d   = 4'd0;
            state_d = load_err ? ERR : MUL;
         end
         MUL: begin
            if (n_q[0]) acc_d = acc_q + mcand_q;
            mcand_d = {mcand_q[56:0], 1'b0};
            n_d     = {1'b0, n_q[9:1]};
            cnt_d   = cnt_q + 4'd1;
            if (cnt_q == 4'd9) state_d = DONE;
         end
         DONE: begin
`ifdef TW_ROUND_EN
            tw_d = tw_round(acc_q[47:15]);
`else
            tw_d = acc_q[47:16];
`endif
            wv_d    = 1'b1;
            rerr_d  = 1'b0;
            state_d = IDLE;
         end
         ERR: begin
            rerr_d = 1'b1;
            if (CLR_ON_ERR != 0) tw_d = 32'd0;
            state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   // State, edge detector, multiplier and output registers.
   always_ff @(posedge clk_4MHz or posedge rst) begin
      if (rst) begin
         state_q <= IDLE;
         fsel_q  <= 1'b0;
         arm_q   <= 1'b0;
         n_q     <= 10'd0;
         mcand_q <= 58'd0;
         acc_q   <= 58'd0;
         cnt_q   <= 4'd0;
         tw_q    <= 32'd0;
         wv_q    <= 1'b0;
         rerr_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         fsel_q  <= freq_select;
         arm_q   <= arm_d;
         n_q     <= n_d;
         mcand_q <= mcand_d;
         acc_q   <= acc_d;
         cnt_q   <= cnt_d;
         tw_q    <= tw_d;
         wv_q    <= wv_d;
         rerr_q  <= rerr_d;
      end
   end

   // Snapshot the entry on acceptance so keypad activity while busy is ignored.
   always_ff @(posedge clk_4MHz) begin
      if (accept) begin
         d0_q   <= digit0;
         d1_q   <= digit1;
         d2_q   <= digit2;
         unit_q <= unit;
      end
   end

   assign tuning_word = tw_q;
   assign word_valid  = wv_q;
   assign busy        = (state_q != IDLE);
   assign range_err   = rerr_q;

endmodule
